spike_tx_channel: RTL

- Per-input-channel spike transmitter: the sending end of the req/ack spike interface that hidden-layer neurons consume on their spikes_in / address_in / acks_out ports.
- Buffers spike events (4-bit synapse addresses) from the input encoder in a small FIFO.
- Presents them one at a time as spike_out + address_out, holding both stable until ack_in.
- Forces one return-to-zero cycle between events and abandons requests that are never acknowledged.

---
 rtl/spike_tx_channel.sv | 117 +++++++++++
 1 files changed

// File: rtl/spike_tx_channel.sv
// Spike transmitter for one input channel. Encoder events are queued in a
// small FIFO and sent one at a time on a req/ack handshake. Each request is
// followed by one return-to-zero cycle. A request that is never acknowledged
// is abandoned after TIMEOUT cycles.
module spike_tx_channel #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     ev_valid,
  input  logic [ADDR_W-1:0]        ev_addr,
  output logic                     ev_ready,
  output logic                     spike_out,
  output logic [ADDR_W-1:0]        address_out,
  input  logic                     ack_in,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               drop_count,
  output logic [7:0]               timeout_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [7:0] TO_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, REQ, RTZ} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [7:0]        timer, timer_nx;
  logic              spike_nx;
  logic              to_hit;
  logic              pop, push, drop;

  // Head leaves the FIFO whenever no request is outstanding (IDLE or RTZ).
  assign pop      = (state != REQ) && (fifo_count != '0);
  assign ev_ready = resetn && ((fifo_count < FULL) || pop);
  assign push     = ev_valid && ev_ready;
  assign drop     = ev_valid && !ev_ready;

  // Next-state and request-line logic for the handshake.
  always_comb begin
    state_nx = state;
    spike_nx = spike_out;
    timer_nx = timer;
    to_hit   = 1'b0;
    case (state)
      IDLE, RTZ: begin
        if (pop) begin
          state_nx = REQ;
          spike_nx = 1'b1;
          timer_nx = '0;
        end else begin
          state_nx = IDLE;
          spike_nx = 1'b0;
        end
      end
      REQ: begin
        if (ack_in) begin
          state_nx = RTZ;
          spike_nx = 1'b0;
        end else if (TO_EN && (timer == TO_LAST)) begin
          state_nx = RTZ;
          spike_nx = 1'b0;
          to_hit   = 1'b1;
        end else begin
          timer_nx = timer + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        spike_nx = 1'b0;
      end
    endcase
  end

  // State, outputs, pointers and counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      spike_out     <= 1'b0;
      address_out   <= '0;
      timer         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      drop_count    <= '0;
      timeout_count <= '0;
    end else begin
      state     <= state_nx;
      spike_out <= spike_nx;
      timer     <= timer_nx;
      if (pop) begin
        address_out <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + PTR_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      if (to_hit && (timeout_count != 8'hFF)) timeout_count <= timeout_count + 8'd1;
    end
  end

  // FIFO storage; write is gated by ev_ready, so nothing is written in reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ev_addr;
  end

endmodule
